// File: rtl/mef_rega_zonas_pkg.sv
// Shared types and constants for the multi-zone fertigation sequencer.
package mef_rega_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_MIX      = 3'd2,
    ST_IRRIGATE = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam int MAX_ZONES        = 8;
  localparam int DEF_ZONES        = 4;
  localparam int DEF_TWIDTH       = 8;
  localparam int DEF_T_MIX        = 10;
  localparam int DEF_T_FLUSH      = 5;
  localparam int DEF_FILL_TIMEOUT = 200;

  // Wide enough for the largest supported zone count; callers slice it down.
  function automatic logic [MAX_ZONES-1:0] onehot(input logic [2:0] idx);
    logic [MAX_ZONES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mef_rega_zonas_if.sv
// Signal bundle between request/sensor logic, the sequencer and the valve drivers.
interface mef_rega_zonas_if #(
  parameter int ZONES  = 4,
  parameter int TWIDTH = 8
);
  import mef_rega_pkg::*;

  // No valid/ready handshake: every input is a level sampled on each clk edge,
  // except tick, a one-clk strobe that advances all timers by one unit.
  logic              tick;
  logic [ZONES-1:0]  zone_req;
  logic              Adub;
  logic              Nv1;
  logic              Nv0;
  logic [TWIDTH-1:0] t_irr;

  logic              Ve;
  logic              Mist;
  logic              Limp;
  logic [ZONES-1:0]  zone_en;
  logic              busy;
  logic              fault;
  state_t            state;

  modport master (
    output tick, zone_req, Adub, Nv1, Nv0, t_irr,
    input  Ve, Mist, Limp, zone_en, busy, fault, state
  );

  modport slave (
    input  tick, zone_req, Adub, Nv1, Nv0, t_irr,
    output Ve, Mist, Limp, zone_en, busy, fault, state
  );

endinterface

// File: rtl/mef_rega_zonas_rr_arbiter.sv
// Round-robin zone picker: first pending request strictly after ptr, wrapping.
module rr_arbiter_zonas #(
  parameter  int ZONES = 4,
  localparam int ZW    = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic [ZONES-1:0] req,
  input  logic [ZW-1:0]    ptr,
  output logic [ZW-1:0]    grant,
  output logic             any_req
);

  always_comb begin
    logic [ZW-1:0] idx;
    idx     = '0;
    grant   = '0;
    any_req = 1'b0;
    for (int i = 1; i <= ZONES; i++) begin
      idx = ZW'((int'(ptr) + i) % ZONES);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/mef_rega_zonas.sv
// Multi-zone irrigation sequencer: tank refill, optional fertiliser mix,
// timed zone irrigation and post-fertigation line flush, in timebase ticks.
module mef_rega_zonas
  import mef_rega_pkg::*;
#(
  parameter int ZONES        = DEF_ZONES,
  parameter int TWIDTH       = DEF_TWIDTH,
  parameter int T_MIX        = DEF_T_MIX,
  parameter int T_FLUSH      = DEF_T_FLUSH,
  parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT
) (
  input  logic      clk,
  input  logic      reset,
  mef_rega_zonas_if.slave bus
);

  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int FW = $clog2(FILL_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [ZW-1:0]     zone, zone_nxt;
  logic [ZW-1:0]     ptr, ptr_nxt;
  logic [ZW-1:0]     grant;
  logic              any_req;
  logic              fert, fert_nxt, fert_sel;
  logic              pend, pend_nxt;
  logic [TWIDTH-1:0] timer, timer_nxt, t_load;
  logic [FW-1:0]     fill_cnt, fill_nxt;
  logic              expire;
  logic [MAX_ZONES-1:0] zone_oh;

  rr_arbiter_zonas #(.ZONES(ZONES)) u_arb (
    .req     (bus.zone_req),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      zone     <= '0;
      ptr      <= ZW'(ZONES - 1);
      fert     <= 1'b0;
      pend     <= 1'b0;
      timer    <= '0;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      zone     <= zone_nxt;
      ptr      <= ptr_nxt;
      fert     <= fert_nxt;
      pend     <= pend_nxt;
      timer    <= timer_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  // pend marks a zone whose MIX/IRRIGATE was cut short by low water; it is
  // re-served with its latched fert flag even if the request has dropped.
  always_comb begin
    state_nxt = state;
    zone_nxt  = zone;
    ptr_nxt   = ptr;
    fert_nxt  = fert;
    pend_nxt  = pend;
    timer_nxt = timer;
    fill_nxt  = '0;
    t_load    = (bus.t_irr == '0) ? TWIDTH'(1) : bus.t_irr;
    fert_sel  = pend ? fert : bus.Adub;
    expire    = bus.tick && (timer == TWIDTH'(1));

    if (bus.Nv1 && !bus.Nv0) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend || any_req) begin
            if (!bus.Nv0) begin
              state_nxt = ST_FILL;
            end else begin
              if (!pend) zone_nxt = grant;
              fert_nxt = fert_sel;
              pend_nxt = 1'b0;
              if (fert_sel) begin
                state_nxt = ST_MIX;
                timer_nxt = TWIDTH'(T_MIX);
              end else begin
                state_nxt = ST_IRRIGATE;
                timer_nxt = t_load;
              end
            end
          end
        end
        ST_FILL: begin
          fill_nxt = fill_cnt;
          if (bus.Nv1) begin
            state_nxt = ST_IDLE;
          end else if (bus.tick) begin
            if (fill_cnt == FW'(FILL_TIMEOUT - 1)) state_nxt = ST_FAULT;
            else fill_nxt = fill_cnt + FW'(1);
          end
        end
        ST_MIX: begin
          if (expire) begin
            state_nxt = ST_IRRIGATE;
            timer_nxt = t_load;
          end else if (!bus.Nv0) begin
            state_nxt = ST_FILL;
            pend_nxt  = 1'b1;
          end else if (bus.tick) begin
            timer_nxt = timer - TWIDTH'(1);
          end
        end
        ST_IRRIGATE: begin
          if (expire) begin
            if (fert) begin
              state_nxt = ST_FLUSH;
              timer_nxt = TWIDTH'(T_FLUSH);
            end else begin
              state_nxt = ST_IDLE;
              ptr_nxt   = zone;
            end
          end else if (!bus.Nv0) begin
            state_nxt = ST_FILL;
            pend_nxt  = 1'b1;
          end else if (bus.tick) begin
            timer_nxt = timer - TWIDTH'(1);
          end
        end
        ST_FLUSH: begin
          if (expire) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = zone;
            fert_nxt  = 1'b0;
          end else if (bus.tick) begin
            timer_nxt = timer - TWIDTH'(1);
          end
        end
        ST_FAULT: begin
        end
        default: state_nxt = ST_FAULT;
      endcase
    end
  end

  assign zone_oh     = onehot(3'(zone));
  assign bus.Ve      = (state == ST_FILL);
  assign bus.Mist    = (state == ST_MIX);
  assign bus.Limp    = (state == ST_FLUSH);
  assign bus.zone_en = (state == ST_IRRIGATE || state == ST_FLUSH) ? zone_oh[ZONES-1:0] : '0;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.fault   = (state == ST_FAULT);
  assign bus.state   = state;

endmodule

// File: tb/tb_mef_rega_zonas.sv
// Bench for mef_rega_zonas: table of single-grant cycles checked through a
// segment scoreboard, plus hand-written refill, fault and reset sequences.
module tb_mef_rega_zonas;
  import mef_rega_pkg::*;

  localparam int Z  = 4;
  localparam int WW = 5 + Z;
  localparam int EW = 1 + 8 + WW;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mef_rega_zonas_if #(.ZONES(Z), .TWIDTH(8)) bus ();

  mef_rega_zonas #(
    .ZONES(Z), .TWIDTH(8), .T_MIX(10), .T_FLUSH(5), .FILL_TIMEOUT(200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // segment = {care_ticks, ticks, {fault,busy,Ve,Mist,Limp,zone_en}}
  logic [EW-1:0] exp_q[$];
  logic [WW-1:0] cur_word = '0;
  int            cur_ticks = 0;
  int            tick_div = 0;
  logic          tick_mode = 1'b0;

  function automatic logic [EW-1:0] seg(input logic [WW-1:0] w, input int t, input logic care);
    return {care, 8'(t), w};
  endfunction
  function automatic logic [WW-1:0] w_irr(input logic [Z-1:0] z);
    return {5'b01000, z};
  endfunction
  function automatic logic [WW-1:0] w_flush(input logic [Z-1:0] z);
    return {5'b01001, z};
  endfunction
  localparam logic [WW-1:0] W_MIX   = {5'b01010, 4'b0000};
  localparam logic [WW-1:0] W_FILL  = {5'b01100, 4'b0000};
  localparam logic [WW-1:0] W_FAULT = {5'b11000, 4'b0000};

  function automatic logic [WW-1:0] sample();
    return {bus.fault, bus.busy, bus.Ve, bus.Mist, bus.Limp, bus.zone_en};
  endfunction

  // Monitor: closes a segment whenever the output word changes and scores
  // busy segments; also owns the tick strobe (ticks counted against the
  // word that was present when the strobe was sampled).
  always @(negedge clk) begin
    logic [WW-1:0] nw;
    logic [EW-1:0] e;
    nw = sample();
    if (bus.tick && cur_ticks < 255) cur_ticks++;
    if (nw != cur_word) begin
      if (cur_word[WW-2]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL seg_unexpected: got word=%b ticks=%0d, required no segment", cur_word, cur_ticks);
        end else begin
          e = exp_q.pop_front();
          if (e[WW-1:0] != cur_word || (e[EW-1] && int'(e[EW-2:WW]) != cur_ticks)) begin
            errors++;
            $display("FAIL seg: got word=%b ticks=%0d, required word=%b ticks=%0d (care=%0b)",
                     cur_word, cur_ticks, e[WW-1:0], e[EW-2:WW], e[EW-1]);
          end
        end
      end
      if (!nw[WW-2]) begin
        checks++;
        if (nw != '0) begin
          errors++;
          $display("FAIL idle_outputs: got %b, required %b", nw, {WW{1'b0}});
        end
      end
      cur_word  = nw;
      cur_ticks = 0;
    end
    if (tick_mode) begin
      bus.tick = 1'b1;
    end else begin
      tick_div = (tick_div == 2) ? 0 : tick_div + 1;
      bus.tick = (tick_div == 0);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return bus.Limp;
      1:       return bus.Mist;
      2:       return bus.zone_en == 4'b0100;
      3:       return bus.fault;
      default: return cur_ticks >= 2;
    endcase
  endfunction

  task automatic wait_until(input int which, input int budget, input string name);
    int n = 0;
    while (!cond(which) && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(cond(which)), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [Z-1:0] req;
    logic         adub;
    logic [7:0]   t;
    logic [Z-1:0] z;
    int           mix;
    int           irr;
    int           flush;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // pointer starts at 3 and follows each completed grant
    vecs[0] = '{4'b0101, 1'b0, 8'd3, 4'b0001, 0,  3, 0};
    vecs[1] = '{4'b0101, 1'b0, 8'd3, 4'b0100, 0,  3, 0};
    vecs[2] = '{4'b0101, 1'b0, 8'd3, 4'b0001, 0,  3, 0};
    vecs[3] = '{4'b0010, 1'b1, 8'd4, 4'b0010, 10, 4, 5};
    vecs[4] = '{4'b0011, 1'b0, 8'd0, 4'b0001, 0,  1, 0};
    vecs[5] = '{4'b1111, 1'b0, 8'd2, 4'b0010, 0,  2, 0};
    vecs[6] = '{4'b1001, 1'b0, 8'd7, 4'b1000, 0,  7, 0};
    vecs[7] = '{4'b1000, 1'b1, 8'd1, 4'b1000, 10, 1, 5};
    vecs[8] = '{4'b1111, 1'b0, 8'd5, 4'b0001, 0,  5, 0};

    // reset held with toggling inputs
    reset = 1'b0;
    bus.zone_req = '0; bus.Adub = 1'b0; bus.Nv1 = 1'b1; bus.Nv0 = 1'b1; bus.t_irr = 8'd3;
    for (int i = 0; i < 5; i++) begin
      bus.zone_req = 4'($urandom_range(0, 15));
      bus.Adub     = 1'($urandom_range(0, 1));
      bus.Nv1      = 1'($urandom_range(0, 1));
      bus.Nv0      = 1'($urandom_range(0, 1));
      bus.t_irr    = 8'($urandom_range(0, 255));
      step(1);
      check("reset_outputs", 32'(sample()), 32'd0);
    end
    bus.zone_req = '0; bus.Adub = 1'b0; bus.Nv1 = 1'b1; bus.Nv0 = 1'b1; bus.t_irr = 8'd3;
    step(1);
    reset = 1'b1;
    step(5);
    check("idle_after_reset_busy", 32'(bus.busy), 32'd0);
    check("idle_after_reset_state", 32'(bus.state), 32'(ST_IDLE));

    // tick held high in IDLE with no request
    tick_mode = 1'b1;
    step(12);
    check("tick_high_idle", 32'(sample()), 32'd0);
    tick_mode = 1'b0;

    // table of single-grant cycles
    foreach (vecs[k]) begin
      bus.zone_req = vecs[k].req;
      bus.Adub     = vecs[k].adub;
      bus.t_irr    = vecs[k].t;
      if (vecs[k].mix > 0) exp_q.push_back(seg(W_MIX, vecs[k].mix, 1'b1));
      exp_q.push_back(seg(w_irr(vecs[k].z), vecs[k].irr, 1'b1));
      if (vecs[k].flush > 0) exp_q.push_back(seg(w_flush(vecs[k].z), vecs[k].flush, 1'b1));
      wait_drain(400, $sformatf("vec%0d_drain", k));
      bus.zone_req = '0;
      bus.Adub     = 1'b0;
      step(3);
      check($sformatf("vec%0d_idle", k), 32'(bus.busy), 32'd0);
    end

    // refill interrupt during zone 2, then full t_irr reload
    bus.zone_req = 4'b0100; bus.t_irr = 8'd6;
    exp_q.push_back(seg(w_irr(4'b0100), 0, 1'b0));
    exp_q.push_back(seg(W_FILL, 0, 1'b0));
    exp_q.push_back(seg(w_irr(4'b0100), 6, 1'b1));
    wait_until(2, 20, "refill_zone2_start");
    wait_until(4, 20, "refill_two_ticks");
    bus.Nv1 = 1'b0;
    step(1);
    bus.Nv0 = 1'b0;
    step(1);
    check("refill_ve", 32'(bus.Ve), 32'd1);
    check("refill_zone_off", 32'(bus.zone_en), 32'd0);
    step(8);
    bus.Nv0 = 1'b1;
    step(5);
    check("refill_wait_high", 32'(bus.state), 32'(ST_FILL));
    bus.Nv1 = 1'b1;
    wait_drain(100, "refill_drain");
    bus.zone_req = '0;
    step(3);

    // invalid sensor pair during MIX
    bus.zone_req = 4'b0010; bus.Adub = 1'b1; bus.t_irr = 8'd4;
    exp_q.push_back(seg(W_MIX, 0, 1'b0));
    exp_q.push_back(seg(W_FAULT, 0, 1'b0));
    wait_until(1, 10, "mixfault_mix");
    step(2);
    bus.Nv1 = 1'b1; bus.Nv0 = 1'b0;
    step(1);
    check("mixfault_word", 32'(sample()), 32'(W_FAULT));
    check("mixfault_state", 32'(bus.state), 32'(ST_FAULT));
    for (int i = 0; i < 20; i++) begin
      bus.zone_req = 4'($urandom_range(0, 15));
      bus.Adub     = 1'($urandom_range(0, 1));
      bus.Nv1      = 1'($urandom_range(0, 1));
      bus.Nv0      = 1'($urandom_range(0, 1));
      step(1);
    end
    check("mixfault_sticky", 32'(sample()), 32'(W_FAULT));
    bus.zone_req = '0; bus.Adub = 1'b0; bus.Nv1 = 1'b1; bus.Nv0 = 1'b1;
    reset = 1'b0;
    step(1);
    check("mixfault_reset_clears", 32'(sample()), 32'd0);
    reset = 1'b1;
    wait_drain(5, "mixfault_drain");

    // FILL timeout with high sensor stuck low
    bus.Nv1 = 1'b0; bus.Nv0 = 1'b0; bus.zone_req = 4'b0001;
    exp_q.push_back(seg(W_FILL, 200, 1'b1));
    exp_q.push_back(seg(W_FAULT, 0, 1'b0));
    wait_until(3, 700, "filltimeout_fault");
    bus.zone_req = '0; bus.Nv1 = 1'b1; bus.Nv0 = 1'b1;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    wait_drain(5, "filltimeout_drain");

    // reset asserted mid-FLUSH drops outputs without waiting for a clock
    bus.zone_req = 4'b0010; bus.Adub = 1'b1; bus.t_irr = 8'd4;
    exp_q.push_back(seg(W_MIX, 10, 1'b1));
    exp_q.push_back(seg(w_irr(4'b0010), 4, 1'b1));
    exp_q.push_back(seg(w_flush(4'b0010), 0, 1'b0));
    wait_until(0, 100, "flushreset_limp");
    step(1);
    reset = 1'b0;
    #1;
    check("flushreset_limp_off", 32'(bus.Limp), 32'd0);
    check("flushreset_zone_off", 32'(bus.zone_en), 32'd0);
    bus.zone_req = '0; bus.Adub = 1'b0;
    step(2);
    reset = 1'b1;
    wait_drain(5, "flushreset_drain");

    step(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mef_rega_zonas.md
Name: mef_rega_zonas

Overview:
- Parametrised successor of the single-line fertigation/cleaning FSM.
- Sequences irrigation across ZONES valve zones using round-robin arbitration.
- Manages tank refill from the two level sensors, and runs an optional timed fertiliser-mix phase before a zone plus a timed line flush after it.
- Sits between the soil-sensor/request logic and the valve drivers; all timing is counted in ticks of an external timebase enable.

Parameters:
- ZONES, 4, number of irrigation zones (2..8).
- TWIDTH, 8, width of tick counters and of t_irr.
- T_MIX, 10, ticks of fertiliser mixing (Mist) before a fertigated zone.
- T_FLUSH, 5, ticks of line cleaning (Limp) after a fertigated zone.
- FILL_TIMEOUT, 200, maximum ticks in FILL before declaring fault.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted; deassertion synchronous to clk).
- tick  in  1  one-clk timebase enable; all durations are counted in ticks.
- zone_req  in  ZONES  per-zone irrigation request (level; 1 = soil dry).
- Adub  in  1  fertigation mode; sampled on IDLE exit.
- Nv1  in  1  tank high-level sensor (1 = water at/above high mark).
- Nv0  in  1  tank low-level sensor (1 = water at/above low mark).
- t_irr  in  TWIDTH  irrigation duration per zone in ticks; sampled on IRRIGATE entry.
- Ve  out  1  tank fill valve.
- Mist  out  1  fertiliser mixer/injector.
- Limp  out  1  line flush valve.
- zone_en  out  ZONES  one-hot zone valve enable (all zero outside IRRIGATE/FLUSH).
- busy  out  1  state != IDLE.
- fault  out  1  sticky fault indicator.

Behaviour:
- Moore machine. All outputs decode from registered state/zone only; there is no combinational input-to-output path.
- Reset values: state=IDLE, Ve=Mist=Limp=0, zone_en=0, busy=0, fault=0, rr pointer=ZONES-1 (so zone 0 has priority first), fert flag=0, timer=0.
- States: IDLE, FILL, MIX, IRRIGATE, FLUSH, FAULT.
- Invalid sensor pair Nv1=1 & Nv0=0 in any state -> FAULT on the next edge. This overrides every other transition.
- IDLE:
  - No zone_req -> stay in IDLE.
  - Otherwise, if Nv0=0 -> FILL.
  - Otherwise grant zone g = first set zone_req searching upward from pointer+1, modulo ZONES. Latch g and fert=Adub.
  - fert=1 -> MIX, timer=T_MIX; fert=0 -> IRRIGATE.
- FILL:
  - Ve=1.
  - Nv1=1 -> IDLE (re-arbitrate; granted zone and pointer unchanged).
  - FILL_TIMEOUT ticks elapsed -> FAULT.
- MIX:
  - Mist=1.
  - Timer decrements on tick; on the tick where timer==1 -> IRRIGATE.
  - Nv0=0 -> FILL, and MIX restarts afterwards.
- IRRIGATE:
  - zone_en[g]=1.
  - Timer loaded with t_irr on entry; t_irr=0 is treated as 1.
  - Expiry with fert=1 -> FLUSH, timer=T_FLUSH. Expiry with fert=0 -> IDLE, pointer=g.
  - Nv0=0 mid-irrigation -> FILL. Zone g stays pending and the pointer is not advanced. On return the remaining time is discarded and t_irr is reloaded.
- FLUSH:
  - zone_en[g]=1 and Limp=1.
  - Expiry -> IDLE, pointer=g, fert=0.
  - Low level is ignored during FLUSH.
- FAULT:
  - All actuators 0, fault=1.
  - Exits only via reset.
- zone_req deassertion after grant does not abort the cycle.
- Simultaneous events: sensor fault beats timer expiry; timer expiry beats low level.
- tick is ignored in IDLE and FAULT.
- Reset mid-operation forces all actuators off asynchronously.

Decomposition:
- Package mef_rega_pkg holds:
  - the state enum (3-bit encoding);
  - the default timing constants;
  - a function onehot(idx).
- One natural sub-module: rr_arbiter_zonas (ZONES, combinational). Inputs: req and pointer. Outputs: grant index and any_req.

Test Plan:
- Reset: hold reset=0, toggle inputs -> all outputs 0, busy=0. Release with Nv1=Nv0=1, zone_req=0 -> remains IDLE.
- Plain irrigation: Nv1=Nv0=1, Adub=0, zone_req=4'b0101, t_irr=3 -> zone_en=0001 for exactly 3 ticks, back to IDLE, then 0100 for 3 ticks, then back to zone 0 (round-robin).
- Fertigation: Adub=1, zone_req=4'b0010, t_irr=4 -> Mist for 10 ticks, then zone_en=0010 for 4 ticks, then Limp with zone_en=0010 for 5 ticks, then IDLE with fert cleared.
- Refill interrupt: during zone 2 irrigation drop Nv0=0 -> Ve=1, zone_en=0. Raise Nv0 then Nv1 -> IDLE regrants zone 2 with the full t_irr reloaded.
- Faults:
  - Nv1=1, Nv0=0 while in MIX -> FAULT next edge, fault=1, all actuators 0, stays there until reset.
  - Separately, with Nv1 stuck 0 in FILL -> fault after 200 ticks.
- Edge cases:
  - t_irr=0 -> zone on for one tick.
  - Reset asserted mid-FLUSH -> Limp and zone_en drop immediately.
  - tick held high in IDLE has no effect.
